// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_control_unit
// Description : Control path of a 5-stage RV32 pipeline. Decodes the ID-stage
//               opcode into a control bundle, carries it through the ID/EX,
//               EX/MEM and MEM/WB control registers, and resolves hazards:
//               external memory stall, multi-cycle mul/div occupancy of EX,
//               taken-branch flush and load-use stall (in that priority).
// Ports       : clk, rst_n                    clock, async active-low reset
//               i_op_id, i_funct7_id          ID-stage opcode / funct7
//               i_rs1_id, i_rs2_id, i_rd_id   ID-stage register indices
//               i_branch_taken_ex             branch in EX resolved taken
//               i_stall_ext                   freeze the whole pipe
//               o_*_ex / o_*_mem / o_*_wb     per-stage control outputs
//               o_stall_if_id, o_flush_if_id  front-end hold / squash
//               o_muldiv_busy                 mul/div occupying EX
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_control_unit #(
  parameter int REG_AW     = 5,
  parameter int MULDIV_EN  = 1,
  parameter int MULDIV_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        i_op_id,
  input  logic [6:0]        i_funct7_id,
  input  logic [REG_AW-1:0] i_rs1_id,
  input  logic [REG_AW-1:0] i_rs2_id,
  input  logic [REG_AW-1:0] i_rd_id,
  input  logic              i_branch_taken_ex,
  input  logic              i_stall_ext,
  output logic              o_reg_write_ex,
  output logic              o_alu_src_ex,
  output logic              o_branch_ex,
  output logic [1:0]        o_alu_op_ex,
  output logic [6:0]        o_op_ex,
  output logic [REG_AW-1:0] o_rd_ex,
  output logic [REG_AW-1:0] o_rd_mem,
  output logic [REG_AW-1:0] o_rd_wb,
  output logic              o_reg_write_mem,
  output logic              o_mem_write_mem,
  output logic              o_mem_read_mem,
  output logic              o_mem_to_reg_mem,
  output logic              o_reg_write_wb,
  output logic              o_mem_to_reg_wb,
  output logic              o_stall_if_id,
  output logic              o_flush_if_id,
  output logic              o_muldiv_busy
);

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_F7_MULDIV = 7'b0000001;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // A latency of 1 means mul/div behaves like any single-cycle ALU op.
  localparam logic       c_LAT_MULTI = (MULDIV_LAT > 1);
  localparam logic [3:0] c_CNT_INIT  = (MULDIV_LAT > 1) ? 4'(MULDIV_LAT - 2) : 4'd0;
  localparam logic       c_MD_EN     = (MULDIV_EN != 0);

  typedef struct packed {
    logic              rw;
    logic              as;
    logic              br;
    logic [1:0]        aop;
    logic              mw;
    logic              mr;
    logic              m2r;
    logic              md;
    logic [REG_AW-1:0] rd;
    logic [6:0]        op;
  } ctrl_t;

  ctrl_t             w_dec;
  ctrl_t             r_idex;
  logic              r_exmem_rw, r_exmem_mw, r_exmem_mr, r_exmem_m2r;
  logic [REG_AW-1:0] r_exmem_rd;
  logic              r_memwb_rw, r_memwb_m2r;
  logic [REG_AW-1:0] r_memwb_rd;
  logic [0:0]        r_state;
  logic [3:0]        r_cnt;

  logic w_md_in_ex;
  logic w_load_use;

  // --------------------------------------------------------------------------
  // ID-stage decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_dec    = '0;
    w_dec.rd = i_rd_id;
    w_dec.op = i_op_id;
    case (i_op_id)
      c_OP_LOAD: begin
        w_dec.rw  = 1'b1;
        w_dec.as  = 1'b1;
        w_dec.mr  = 1'b1;
        w_dec.m2r = 1'b1;
      end
      c_OP_RTYPE: begin
        w_dec.rw  = 1'b1;
        w_dec.aop = 2'b10;
        w_dec.md  = c_MD_EN && (i_funct7_id == c_F7_MULDIV);
      end
      c_OP_ITYPE, c_OP_JALR: begin
        w_dec.rw = 1'b1;
        w_dec.as = 1'b1;
      end
      c_OP_JAL, c_OP_LUI, c_OP_AUIPC: begin
        w_dec.rw = 1'b1;
      end
      c_OP_STORE: begin
        w_dec.as = 1'b1;
        w_dec.mw = 1'b1;
      end
      c_OP_BRANCH: begin
        w_dec.br  = 1'b1;
        w_dec.aop = 2'b01;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  // A mul/div op holds EX from the cycle it arrives (FSM still IDLE, counter
  // being loaded) until the BUSY cycle where the count reaches zero. The
  // arrival cycle must already freeze ID/EX, otherwise the op would slip
  // into EX/MEM after one cycle.
  assign w_md_in_ex = r_idex.md && c_LAT_MULTI;

  // rs2 is compared even for I-type ops: a spurious stall is harmless.
  assign w_load_use = r_idex.mr && (r_idex.rd != '0) &&
                      ((r_idex.rd == i_rs1_id) || (r_idex.rd == i_rs2_id));

  // Gated with rst_n so the front-end sees no hold/squash while in reset.
  assign o_stall_if_id = rst_n &&
                         (i_stall_ext || w_md_in_ex || (!i_branch_taken_ex && w_load_use));
  assign o_flush_if_id = rst_n && !i_stall_ext && !w_md_in_ex && i_branch_taken_ex;
  assign o_muldiv_busy = (r_state == S_BUSY);

  // --------------------------------------------------------------------------
  // Stage registers and mul/div FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex      <= '0;
      r_exmem_rw  <= 1'b0;
      r_exmem_mw  <= 1'b0;
      r_exmem_mr  <= 1'b0;
      r_exmem_m2r <= 1'b0;
      r_exmem_rd  <= '0;
      r_memwb_rw  <= 1'b0;
      r_memwb_m2r <= 1'b0;
      r_memwb_rd  <= '0;
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
    end else if (!i_stall_ext) begin
      // MEM/WB advances in every non-frozen cycle.
      r_memwb_rw  <= r_exmem_rw;
      r_memwb_m2r <= r_exmem_m2r;
      r_memwb_rd  <= r_exmem_rd;

      if (w_md_in_ex) begin
        if (r_state == S_IDLE) begin
          r_state     <= S_BUSY;
          r_cnt       <= c_CNT_INIT;
          r_exmem_rw  <= 1'b0;
          r_exmem_mw  <= 1'b0;
          r_exmem_mr  <= 1'b0;
          r_exmem_m2r <= 1'b0;
          r_exmem_rd  <= '0;
        end else if (r_cnt == 4'd0) begin
          // Op leaves EX. IF/ID is still held this cycle, so ID/EX takes a
          // bubble rather than the held ID instruction.
          r_state     <= S_IDLE;
          r_exmem_rw  <= r_idex.rw;
          r_exmem_mw  <= r_idex.mw;
          r_exmem_mr  <= r_idex.mr;
          r_exmem_m2r <= r_idex.m2r;
          r_exmem_rd  <= r_idex.rd;
          r_idex      <= '0;
        end else begin
          r_cnt       <= r_cnt - 4'd1;
          r_exmem_rw  <= 1'b0;
          r_exmem_mw  <= 1'b0;
          r_exmem_mr  <= 1'b0;
          r_exmem_m2r <= 1'b0;
          r_exmem_rd  <= '0;
        end
      end else begin
        r_exmem_rw  <= r_idex.rw;
        r_exmem_mw  <= r_idex.mw;
        r_exmem_mr  <= r_idex.mr;
        r_exmem_m2r <= r_idex.m2r;
        r_exmem_rd  <= r_idex.rd;
        if (i_branch_taken_ex || w_load_use) begin
          r_idex <= '0;
        end else begin
          r_idex <= w_dec;
        end
      end
    end
  end

  assign o_reg_write_ex   = r_idex.rw;
  assign o_alu_src_ex     = r_idex.as;
  assign o_branch_ex      = r_idex.br;
  assign o_alu_op_ex      = r_idex.aop;
  assign o_op_ex          = r_idex.op;
  assign o_rd_ex          = r_idex.rd;
  assign o_reg_write_mem  = r_exmem_rw;
  assign o_mem_write_mem  = r_exmem_mw;
  assign o_mem_read_mem   = r_exmem_mr;
  assign o_mem_to_reg_mem = r_exmem_m2r;
  assign o_rd_mem         = r_exmem_rd;
  assign o_reg_write_wb   = r_memwb_rw;
  assign o_mem_to_reg_wb  = r_memwb_m2r;
  assign o_rd_wb          = r_memwb_rd;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_control_unit
// Description : Self-checking bench for pipelined_control_unit. Two instances
//               (mul/div enabled and disabled, latency 4) share one stimulus
//               stream; each is compared every cycle against an age-based
//               behavioural model of the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_control_unit;

  localparam int LAT = 4;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_BAD  = 7'b1111111;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef struct packed {
    logic       rw, as, br;
    logic [1:0] aop;
    logic       mw, mr, m2r, md;
    logic [4:0] rd;
    logic [6:0] op;
  } stage_t;

  typedef struct packed {
    logic       rw_ex, as_ex, br_ex;
    logic [1:0] aop_ex;
    logic [6:0] op_ex;
    logic [4:0] rd_ex;
    logic       rw_mem, mw_mem, mr_mem, m2r_mem;
    logic [4:0] rd_mem;
    logic       rw_wb, m2r_wb;
    logic [4:0] rd_wb;
    logic       stall, flush, busy;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op, f7;
  logic [4:0] rs1, rs2, rd;
  logic       bt, se;

  outs_t obs [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic       rw_ex, as_ex, br_ex, rw_mem, mw_mem, mr_mem, m2r_mem;
    logic       rw_wb, m2r_wb, stall, flush, busy;
    logic [1:0] aop_ex;
    logic [6:0] op_ex;
    logic [4:0] rd_ex, rd_mem, rd_wb;

    pipelined_control_unit #(
      .REG_AW     (5),
      .MULDIV_EN  ((k == 0) ? 1 : 0),
      .MULDIV_LAT (LAT)
    ) u_dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_op_id           (op),
      .i_funct7_id       (f7),
      .i_rs1_id          (rs1),
      .i_rs2_id          (rs2),
      .i_rd_id           (rd),
      .i_branch_taken_ex (bt),
      .i_stall_ext       (se),
      .o_reg_write_ex    (rw_ex),
      .o_alu_src_ex      (as_ex),
      .o_branch_ex       (br_ex),
      .o_alu_op_ex       (aop_ex),
      .o_op_ex           (op_ex),
      .o_rd_ex           (rd_ex),
      .o_rd_mem          (rd_mem),
      .o_rd_wb           (rd_wb),
      .o_reg_write_mem   (rw_mem),
      .o_mem_write_mem   (mw_mem),
      .o_mem_read_mem    (mr_mem),
      .o_mem_to_reg_mem  (m2r_mem),
      .o_reg_write_wb    (rw_wb),
      .o_mem_to_reg_wb   (m2r_wb),
      .o_stall_if_id     (stall),
      .o_flush_if_id     (flush),
      .o_muldiv_busy     (busy)
    );

    assign obs[k] = {rw_ex, as_ex, br_ex, aop_ex, op_ex, rd_ex,
                     rw_mem, mw_mem, mr_mem, m2r_mem, rd_mem,
                     rw_wb, m2r_wb, rd_wb, stall, flush, busy};
  end

  // ---------------------------------------------------------------- model
  stage_t m_ex [2], m_mem [2], m_wb [2];
  int     m_age [2];  // cycles the mul/div op in EX has spent there (1 on arrival)

  int checks = 0;
  int errors = 0;
  bit last_stall, last_flush;

  function automatic stage_t dec(input logic [6:0] o, input logic [6:0] f,
                                 input logic [4:0] d, input bit en);
    stage_t s = '0;
    s.rd = d;
    s.op = o;
    if (o == OP_LW)  begin s.rw = 1; s.as = 1; s.mr = 1; s.m2r = 1; end
    if (o == OP_R)   begin s.rw = 1; s.aop = 2'd2; s.md = en && (f == F7_MUL); end
    if (o == OP_I || o == OP_JALR) begin s.rw = 1; s.as = 1; end
    if (o == OP_JAL || o == OP_LUI || o == OP_AUI) s.rw = 1;
    if (o == OP_SW)  begin s.as = 1; s.mw = 1; end
    if (o == OP_BEQ) begin s.br = 1; s.aop = 2'd1; end
    return s;
  endfunction

  function automatic bit md_waiting(input int k);
    return m_ex[k].md && (LAT > 1);
  endfunction

  function automatic bit hazard(input int k);
    return m_ex[k].mr && (m_ex[k].rd != 0) && (m_ex[k].rd == rs1 || m_ex[k].rd == rs2);
  endfunction

  function automatic outs_t expect_outs(input int k);
    outs_t e = '0;
    e.rw_ex = m_ex[k].rw;  e.as_ex = m_ex[k].as;  e.br_ex = m_ex[k].br;
    e.aop_ex = m_ex[k].aop; e.op_ex = m_ex[k].op; e.rd_ex = m_ex[k].rd;
    e.rw_mem = m_mem[k].rw; e.mw_mem = m_mem[k].mw; e.mr_mem = m_mem[k].mr;
    e.m2r_mem = m_mem[k].m2r; e.rd_mem = m_mem[k].rd;
    e.rw_wb = m_wb[k].rw; e.m2r_wb = m_wb[k].m2r; e.rd_wb = m_wb[k].rd;
    e.busy = m_ex[k].md && (m_age[k] >= 2);
    if (rst_n) begin
      if (se)                 e.stall = 1;
      else if (md_waiting(k)) e.stall = 1;
      else if (bt)            e.flush = 1;
      else if (hazard(k))     e.stall = 1;
    end
    return e;
  endfunction

  task automatic model_reset(input int k);
    m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_age[k] = 0;
  endtask

  task automatic model_step(input int k);
    if (se) return;
    m_wb[k] = m_mem[k];
    if (md_waiting(k)) begin
      if (m_age[k] == LAT) begin
        m_mem[k] = m_ex[k];
        m_ex[k]  = '0;
        m_age[k] = 0;
      end else begin
        m_mem[k] = '0;
        m_age[k]++;
      end
    end else if (bt || hazard(k)) begin
      m_mem[k] = m_ex[k];
      m_ex[k]  = '0;
    end else begin
      m_mem[k] = m_ex[k];
      m_ex[k]  = dec(op, f7, rd, (k == 0));
      m_age[k] = m_ex[k].md ? 1 : 0;
    end
  endtask

  // ---------------------------------------------------------------- checks
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic cmp(input int k);
    outs_t e = expect_outs(k);
    outs_t o = obs[k];
    string p = $sformatf("u%0d ", k);
    chk({p, "reg_write_ex"},   32'(o.rw_ex),   32'(e.rw_ex));
    chk({p, "alu_src_ex"},     32'(o.as_ex),   32'(e.as_ex));
    chk({p, "branch_ex"},      32'(o.br_ex),   32'(e.br_ex));
    chk({p, "alu_op_ex"},      32'(o.aop_ex),  32'(e.aop_ex));
    chk({p, "op_ex"},          32'(o.op_ex),   32'(e.op_ex));
    chk({p, "rd_ex"},          32'(o.rd_ex),   32'(e.rd_ex));
    chk({p, "reg_write_mem"},  32'(o.rw_mem),  32'(e.rw_mem));
    chk({p, "mem_write_mem"},  32'(o.mw_mem),  32'(e.mw_mem));
    chk({p, "mem_read_mem"},   32'(o.mr_mem),  32'(e.mr_mem));
    chk({p, "mem_to_reg_mem"}, 32'(o.m2r_mem), 32'(e.m2r_mem));
    chk({p, "rd_mem"},         32'(o.rd_mem),  32'(e.rd_mem));
    chk({p, "reg_write_wb"},   32'(o.rw_wb),   32'(e.rw_wb));
    chk({p, "mem_to_reg_wb"},  32'(o.m2r_wb),  32'(e.m2r_wb));
    chk({p, "rd_wb"},          32'(o.rd_wb),   32'(e.rd_wb));
    chk({p, "stall_if_id"},    32'(o.stall),   32'(e.stall));
    chk({p, "flush_if_id"},    32'(o.flush),   32'(e.flush));
    chk({p, "muldiv_busy"},    32'(o.busy),    32'(e.busy));
    if (k == 0) begin
      last_stall = e.stall;
      last_flush = e.flush;
    end
  endtask

  // One clock: drive at negedge, check 1 ns later, advance model at posedge.
  task automatic step(input bit r, input logic [6:0] o, input logic [6:0] f,
                      input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                      input bit t, input bit s);
    @(negedge clk);
    rst_n = r; op = o; f7 = f; rs1 = a; rs2 = b; rd = d; bt = t; se = s;
    if (!r) begin model_reset(0); model_reset(1); end
    #1;
    cmp(0);
    cmp(1);
    @(posedge clk);
    if (rst_n) begin model_step(0); model_step(1); end
  endtask

  task automatic ins(input logic [6:0] o, input logic [6:0] f, input logic [4:0] a,
                     input logic [4:0] b, input logic [4:0] d);
    step(1, o, f, a, b, d, 0, 0);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) ins(OP_I, 7'd0, 5'd0, 5'd0, 5'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [6:0] r_op, r_f7;
    logic [4:0] r_a, r_b, r_d;
    bit         r_bt, r_se;

    rst_n = 0; op = 0; f7 = 0; rs1 = 0; rs2 = 0; rd = 0; bt = 0; se = 0;
    model_reset(0); model_reset(1);

    // Reset held with R-type opcode toggling on the ID input.
    for (int i = 0; i < 4; i++)
      step(0, (i % 2 == 0) ? OP_R : 7'd0, 7'd0, 5'd1, 5'd2, 5'd3, 0, 0);

    // First instruction after release, followed by distinct op classes.
    ins(OP_R, 7'd0, 5'd1, 5'd2, 5'd3);
    ins(OP_SW, 7'd0, 5'd1, 5'd2, 5'd0);
    ins(OP_LUI, 7'd0, 5'd0, 5'd0, 5'd4);
    ins(OP_BAD, 7'd0, 5'd0, 5'd0, 5'd6);
    nops(3);

    // Load-use: lw x5 then add using x5 (held in ID during the stall).
    ins(OP_LW, 7'd0, 5'd1, 5'd0, 5'd5);
    ins(OP_R, 7'd0, 5'd5, 5'd2, 5'd6);
    ins(OP_R, 7'd0, 5'd5, 5'd2, 5'd6);
    nops(3);
    // Same with rd = x0: no stall expected.
    ins(OP_LW, 7'd0, 5'd1, 5'd0, 5'd0);
    ins(OP_R, 7'd0, 5'd0, 5'd2, 5'd6);
    nops(3);

    // Taken branch overriding a load-use hazard, then a normal beq flush.
    ins(OP_LW, 7'd0, 5'd1, 5'd0, 5'd7);
    step(1, OP_R, 7'd0, 5'd7, 5'd7, 5'd8, 1, 0);
    ins(OP_BEQ, 7'd0, 5'd1, 5'd2, 5'd0);
    step(1, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1, 0);
    nops(3);

    // mul followed by nops: EX occupied for LAT cycles on the M-enabled unit.
    ins(OP_R, F7_MUL, 5'd1, 5'd2, 5'd9);
    nops(8);

    // External stall for 3 cycles in the middle of BUSY, branch pulsed.
    ins(OP_R, F7_MUL, 5'd1, 5'd2, 5'd10);
    nops(2);
    step(1, OP_I, 7'd0, 5'd0, 5'd0, 5'd0, 1, 1);
    step(1, OP_I, 7'd0, 5'd0, 5'd0, 5'd0, 1, 1);
    step(1, OP_I, 7'd0, 5'd0, 5'd0, 5'd0, 1, 1);
    nops(6);

    // Reset asserted for one cycle mid-BUSY.
    ins(OP_R, F7_MUL, 5'd1, 5'd2, 5'd11);
    nops(2);
    step(0, OP_I, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    nops(3);

    // Randomised stream; the ID instruction is re-presented while IF/ID is
    // held and replaced by a bubble after a flush.
    r_op = OP_I; r_f7 = 0; r_a = 0; r_b = 0; r_d = 0; r_bt = 0; r_se = 0;
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        if (last_flush) begin
          r_op = 7'd0; r_f7 = 0; r_a = 0; r_b = 0; r_d = 0;
        end else begin
          case ($urandom_range(0, 10))
            0: r_op = OP_LW;   1: r_op = OP_R;   2: r_op = OP_I;
            3: r_op = OP_JAL;  4: r_op = OP_JALR; 5: r_op = OP_LUI;
            6: r_op = OP_AUI;  7: r_op = OP_SW;  8: r_op = OP_BEQ;
            9: r_op = OP_BAD;  default: r_op = OP_LW;
          endcase
          r_f7 = ($urandom_range(0, 3) == 0) ? F7_MUL : 7'd0;
          r_a  = 5'($urandom_range(0, 3));
          r_b  = 5'($urandom_range(0, 3));
          r_d  = 5'($urandom_range(0, 3));
        end
      end
      if (!(r_se && r_bt)) r_bt = m_ex[0].br && ($urandom_range(0, 1) == 1);
      r_se = ($urandom_range(0, 7) == 0);
      step(1, r_op, r_f7, r_a, r_b, r_d, r_bt, r_se);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Successor to the single-cycle opcode decoder for the 5-stage RV32 pipeline. It decodes the ID-stage opcode into the same control bundle, then carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It also owns hazard control: load-use stall, taken-branch flush, external memory stall, and a multi-cycle stall for the optional M-extension.

Parameters:
REG_AW, 5, register-index width
MULDIV_EN, 1, 1 = detect M-extension ops and apply a multi-cycle EX stall
MULDIV_LAT, 4, EX cycles occupied by a mul/div op (1..15); 1 = no stall

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_id  in  7  opcode of instruction in ID
funct7_id  in  7  funct7 of instruction in ID
rs1_id, rs2_id, rd_id  in  REG_AW each  register indices in ID
branch_taken_ex  in  1  branch in EX resolved taken
stall_ext  in  1  data-memory not ready; freeze whole pipe
reg_write_ex, alu_src_ex, branch_ex  out  1 each  ID/EX controls
alu_op_ex  out  2  ID/EX ALUOp
op_ex  out  7  forwarded opcode in EX
rd_ex, rd_mem, rd_wb  out  REG_AW each  destination index per stage
reg_write_mem, mem_write_mem, mem_read_mem, mem_to_reg_mem  out  1 each  EX/MEM controls
reg_write_wb, mem_to_reg_wb  out  1 each  MEM/WB controls
stall_if_id  out  1  hold PC and IF/ID
flush_if_id  out  1  squash IF/ID
muldiv_busy  out  1  mul/div occupying EX

Behaviour:
- Decode is combinational on op_id:
  - RegWrite for 0000011, 0110011, 0010011, 1101111, 1100111, 0110111, 0010111.
  - ALUSrc for 0000011, 0010011, 0100011, 1100111.
  - MemWrite for 0100011.
  - MemRead and MemtoReg for 0000011.
  - Branch for 1100011.
  - ALUOp = 10 for 0110011, 01 for 1100011, else 00.
  - Unknown opcodes decode to all-zero controls.
  - md flag = MULDIV_EN && op_id==0110011 && funct7_id==0000001.
- Bubble = all controls 0, rd 0, op 0000000, md 0.
- Latency: an instruction in ID at cycle n drives the _ex outputs at n+1, _mem at n+2 and _wb at n+3, absent stalls.
- Reset, asynchronous on rst_n low:
  - All three stage registers hold a bubble.
  - Busy counter = 0; FSM = IDLE.
  - Result: every output is 0, including stall_if_id, flush_if_id and muldiv_busy.
  - Asserting reset mid-stall or mid-mul/div aborts immediately.
- Priority per cycle, highest first:
  - 1. stall_ext=1: every register and the counter hold. stall_if_id=1, flush_if_id=0. branch_taken_ex is ignored, so its source holds it until stall_ext falls.
  - 2. FSM BUSY (see below).
  - 3. branch_taken_ex=1: flush_if_id=1, ID/EX loads a bubble, stall_if_id=0, EX/MEM and MEM/WB advance. Overrides the load-use check.
  - 4. Load-use: mem_read of ID/EX (0000011 in EX) && rd_ex!=0 && (rd_ex==rs1_id || rd_ex==rs2_id). Then stall_if_id=1 for exactly one cycle, ID/EX loads a bubble, later stages advance. rs2 is compared even for I-type (conservative).
  - 5. Otherwise all stages advance.
- Mul/div FSM, states IDLE and BUSY:
  - IDLE->BUSY: when the ID/EX register holds md=1 and MULDIV_LAT>1. Load count=MULDIV_LAT-2 the first time EX sees the op.
  - In BUSY: muldiv_busy=1, stall_if_id=1, ID/EX holds, EX/MEM loads a bubble, MEM/WB advances.
  - count decrements each non-stall_ext cycle.
  - BUSY->IDLE when count==0. The op advances to EX/MEM on that transition cycle.
  - Total EX occupancy is MULDIV_LAT cycles.
  - branch_taken_ex is ignored in BUSY; an md op cannot be a branch.
  - A load-use hazard behind a mul/div is evaluated after return to IDLE.
- x0 writes are not special-cased here; the register file ignores rd=0.

Test Plan:
- Reset: hold rst_n=0 with op_id=0110011 toggling -> every output stays 0; release -> first 0110011 gives reg_write_ex=1, alu_op_ex=10 one cycle later, reg_write_wb=1 three cycles later.
- Load-use: lw rd=5, then add rs1=5 -> stall_if_id=1 for one cycle; bubble seen as reg_write_ex=0; add reaches EX the next cycle. Repeat with rd=0 -> no stall.
- Branch flush: beq in EX with branch_taken_ex=1, a load-use hazard also present -> flush_if_id=1, stall_if_id=0, bubble in ID/EX, beq reaches mem stage normally.
- Mul/div: MULDIV_LAT=4, mul (0110011 / 0000001) -> muldiv_busy=1 for 3 cycles and stall_if_id=1 in those cycles; reg_write_mem=1 exactly 4 cycles after EX entry. MULDIV_EN=0 -> treated as a plain R-type.
- External stall: stall_ext=1 for 3 cycles mid-BUSY with branch_taken_ex pulsed -> all outputs frozen, counter resumes, branch ignored.
- Reset mid-BUSY: rst_n low for 1 cycle -> muldiv_busy=0 immediately, all stages hold bubbles.
